// File: rtl/hs_burst_tx_if.sv
// Downstream valid/ready stream carrying the burst beats.
// master: the transmitter side; slave: the receiver side.
interface hs_burst_tx_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  down_valid;
  logic [WORD_WIDTH-1:0] down_data;
  logic                  down_last;
  logic                  down_ready;

  modport master (
    output down_valid,
    output down_data,
    output down_last,
    input  down_ready
  );

  modport slave (
    input  down_valid,
    input  down_data,
    input  down_last,
    output down_ready
  );
endinterface

// File: rtl/hs_burst_tx.sv
// Burst transmitter: on an accepted start it emits len beats, seed, seed+1, ...
// on a valid/ready stream, with an optional idle gap after each non-final
// accepted beat. Every output comes straight from a register, so down_valid
// never depends combinationally on down_ready.
module hs_burst_tx #(
  parameter int WORD_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic [WORD_WIDTH-1:0] seed,
  hs_burst_tx_if.master         down,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_cnt
);

  localparam logic [LEN_WIDTH-1:0]  CNT_ONE  = LEN_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] DATA_ONE = WORD_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = GAP_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state;

  logic                  r_valid,    w_valid;
  logic [WORD_WIDTH-1:0] r_data,     w_data;
  logic                  r_last,     w_last;
  logic                  r_busy,     w_busy;
  logic                  r_done,     w_done;
  logic [LEN_WIDTH-1:0]  r_beat_cnt, w_beat_cnt;
  logic [LEN_WIDTH-1:0]  r_len,      w_len;
  logic [GAP_WIDTH-1:0]  r_gap,      w_gap;
  logic [GAP_WIDTH-1:0]  r_gap_cnt,  w_gap_cnt;

  logic                  w_xfer;
  logic [LEN_WIDTH-1:0]  w_cnt_inc;
  logic [LEN_WIDTH-1:0]  w_len_m1;

  assign w_xfer    = r_valid & down.down_ready;
  assign w_cnt_inc = r_beat_cnt + CNT_ONE;
  // Latched len is never zero while a burst runs, so this cannot underflow.
  assign w_len_m1  = r_len - CNT_ONE;

  // Next-state and next-output logic for the IDLE/SEND/GAP sequencer.
  always_comb begin
    w_state    = r_state;
    w_valid    = r_valid;
    w_data     = r_data;
    w_last     = r_last;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_beat_cnt = r_beat_cnt;
    w_len      = r_len;
    w_gap      = r_gap;
    w_gap_cnt  = r_gap_cnt;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_beat_cnt = '0;
          if (len != '0) begin
            w_len   = len;
            w_gap   = gap;
            w_data  = seed;
            w_valid = 1'b1;
            w_last  = (len == CNT_ONE);
            w_busy  = 1'b1;
            w_state = ST_SEND;
          end else begin
            // Empty burst: report completion without emitting any beat.
            w_done  = 1'b1;
            w_state = ST_IDLE;
          end
        end else begin
          w_state = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (w_xfer) begin
          w_beat_cnt = w_cnt_inc;
          if (r_last) begin
            // Final beat accepted; data keeps its value as a don't-care.
            w_valid = 1'b0;
            w_last  = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = ST_IDLE;
          end else begin
            // Next beat index is w_cnt_inc; it is final when it equals len-1.
            w_data = r_data + DATA_ONE;
            w_last = (w_cnt_inc == w_len_m1);
            if (r_gap == '0) begin
              w_state = ST_SEND;
            end else begin
              w_valid   = 1'b0;
              w_gap_cnt = r_gap;
              w_state   = ST_GAP;
            end
          end
        end else begin
          w_state = ST_SEND;
        end
      end

      ST_GAP: begin
        // Counter holds the remaining idle cycles including the current one.
        if (r_gap_cnt == GAP_ONE) begin
          w_valid = 1'b1;
          w_state = ST_SEND;
        end else begin
          w_gap_cnt = r_gap_cnt - GAP_ONE;
          w_state   = ST_GAP;
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_valid = 1'b0;
        w_last  = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // Sequencer state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Output and burst-context registers; reset abandons any burst silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_beat_cnt <= '0;
      r_len      <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_valid    <= w_valid;
      r_data     <= w_data;
      r_last     <= w_last;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_beat_cnt <= w_beat_cnt;
      r_len      <= w_len;
      r_gap      <= w_gap;
      r_gap_cnt  <= w_gap_cnt;
    end
  end

  assign down.down_valid = r_valid;
  assign down.down_data  = r_data;
  assign down.down_last  = r_last;
  assign busy            = r_busy;
  assign done            = r_done;
  assign beat_cnt        = r_beat_cnt;

endmodule

// File: tb/tb_hs_burst_tx.sv
// Scoreboard bench for hs_burst_tx: stimulus pushes the expected beats and
// done events of each burst into queues; a negedge monitor pops and compares
// whenever a transfer or a done pulse is observed.
module tb_hs_burst_tx;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic [3:0] gap;
  logic [7:0] seed;
  logic       busy;
  logic       done;
  logic [7:0] beat_cnt;

  hs_burst_tx_if #(.WORD_WIDTH(8)) dif ();

  hs_burst_tx #(
    .WORD_WIDTH(8),
    .LEN_WIDTH (8),
    .GAP_WIDTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .gap     (gap),
    .seed    (seed),
    .down    (dif),
    .busy    (busy),
    .done    (done),
    .beat_cnt(beat_cnt)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;   // expected monitor cycle, -1 when not timed
  } beat_t;

  typedef struct {
    logic [7:0] cnt;
    int         cyc;
  } done_t;

  beat_t beat_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: toggle every cycle

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Receiver ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       dif.down_ready = 1'b1;
        1:       dif.down_ready = 1'($urandom_range(0, 1));
        2:       dif.down_ready = ~dif.down_ready;
        default: dif.down_ready = 1'b1;
      endcase
    end
  end

  // Monitor: handshake stability, then scoreboard pops on transfer and done.
  logic       p_rst, p_valid, p_ready, p_last;
  logic [7:0] p_data;
  initial begin
    p_rst = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_last = 1'b0; p_data = 8'h00;
  end

  always @(negedge clk) begin
    beat_t b;
    done_t d;
    if (rst_n === 1'b1) begin
      if (p_rst && p_valid && !p_ready) begin
        chk("hold_valid", 32'(dif.down_valid), 32'd1);
        chk("hold_data", 32'(dif.down_data), 32'(p_data));
        chk("hold_last", 32'(dif.down_last), 32'(p_last));
      end
      if (dif.down_valid === 1'b1) chk("busy_while_valid", 32'(busy), 32'd1);
      if (dif.down_valid === 1'b1 && dif.down_ready === 1'b1) begin
        if (beat_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          b = beat_q.pop_front();
          chk("beat_data", 32'(dif.down_data), 32'(b.data));
          chk("beat_last", 32'(dif.down_last), 32'(b.last));
          if (b.cyc >= 0) chk("beat_cycle", 32'(cyc), 32'(b.cyc));
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          d = done_q.pop_front();
          chk("done_beat_cnt", 32'(beat_cnt), 32'(d.cnt));
          chk("done_busy_low", 32'(busy), 32'd0);
          if (d.cyc >= 0) chk("done_cycle", 32'(cyc), 32'(d.cyc));
        end
      end
    end
    p_rst   = rst_n;
    p_valid = dif.down_valid;
    p_ready = dif.down_ready;
    p_data  = dif.down_data;
    p_last  = dif.down_last;
  end

  // Pulse start for one cycle; when accept is set, queue the expected burst.
  // c0 is the cycle count at which the first beat becomes visible.
  task automatic start_burst(input int l, input int g, input int s,
                             input bit accept, input bit timed, output int c0);
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = 8'(l);
    gap   = 4'(g);
    seed  = 8'(s);
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    len   = 8'($urandom);
    gap   = 4'($urandom);
    seed  = 8'($urandom);
    if (accept) begin
      for (int k = 0; k < l; k++) begin
        beat_t b;
        b.data = 8'(s + k);
        b.last = (k == l - 1);
        b.cyc  = timed ? c0 + k * (g + 1) : -1;
        beat_q.push_back(b);
      end
      begin
        done_t d;
        d.cnt = 8'(l);
        d.cyc = timed ? ((l == 0) ? c0 : c0 + (l - 1) * (g + 1) + 1) : -1;
        done_q.push_back(d);
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((beat_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (beat_q.size() != 0 || done_q.size() != 0) begin
      fail_now({nm, "_timeout"});
      beat_q.delete();
      done_q.delete();
    end
  endtask

  task automatic wait_to(input int target);
    int n = 0;
    while (cyc < target && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, cd, dummy, rl, rg;
    rst_n = 1'b0; start = 1'b0; len = 8'h00; gap = 4'h0; seed = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(dif.down_valid), 32'd0);
    chk("rst_data", 32'(dif.down_data), 32'd0);
    chk("rst_last", 32'(dif.down_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    rst_n = 1'b1;

    // Back-to-back beats, then a payload wrap.
    start_burst(4, 0, 8'h10, 1'b1, 1'b1, c0);
    chk("first_valid_busy", 32'(busy), 32'd1);
    wait_idle(50, "len4");
    chk("len4_beat_cnt", 32'(beat_cnt), 32'd4);
    start_burst(3, 0, 8'hFE, 1'b1, 1'b1, c0);
    wait_idle(50, "wrap");
    chk("wrap_beat_cnt_hold", 32'(beat_cnt), 32'd3);

    // Receiver toggling ready every cycle.
    rdy_mode = 2;
    start_burst(5, 0, 8'h20, 1'b1, 1'b0, c0);
    wait_idle(100, "toggle");
    rdy_mode = 0;

    // Inter-beat gap of two cycles.
    start_burst(3, 2, 8'h30, 1'b1, 1'b1, c0);
    wait_idle(50, "gap2");

    // Start during a burst is ignored; start in the done cycle is accepted.
    start_burst(5, 1, 8'h50, 1'b1, 1'b1, c0);
    cd = c0 + 4 * 2 + 1;
    wait_to(c0 + 3);
    start_burst(9, 0, 8'h99, 1'b0, 1'b0, dummy);
    wait_to(cd - 1);
    start_burst(2, 0, 8'h40, 1'b1, 1'b1, c1);
    chk("restart_cycle", 32'(c1), 32'(cd + 1));
    wait_idle(60, "restart");
    chk("restart_beat_cnt", 32'(beat_cnt), 32'd2);

    // Empty burst.
    start_burst(0, 0, 8'h77, 1'b1, 1'b1, c0);
    chk("len0_no_valid", 32'(dif.down_valid), 32'd0);
    wait_idle(20, "len0");
    chk("len0_beat_cnt", 32'(beat_cnt), 32'd0);

    // Maximum-length burst.
    start_burst(255, 0, 8'hA5, 1'b1, 1'b1, c0);
    wait_idle(400, "len255");
    chk("len255_beat_cnt", 32'(beat_cnt), 32'd255);

    // Randomized bursts with random ready.
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) begin
      rl = $urandom_range(0, 12);
      rg = $urandom_range(0, 3);
      start_burst(rl, rg, $urandom_range(0, 255), 1'b1, 1'b0, c0);
      wait_idle(400, "random");
      chk("random_beat_cnt", 32'(beat_cnt), 32'(rl));
    end
    rdy_mode = 0;

    // Reset while beat index 1 of a six-beat burst is on the bus.
    start_burst(6, 0, 8'h60, 1'b1, 1'b1, c0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    beat_q.delete();
    done_q.delete();
    chk("midrst_valid", 32'(dif.down_valid), 32'd0);
    chk("midrst_data", 32'(dif.down_data), 32'd0);
    chk("midrst_last", 32'(dif.down_last), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle_valid", 32'(dif.down_valid), 32'd0);
    chk("post_rst_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
